// File: rtl/execute_unit_pkg.sv
// Shared types and constants for the execute stage.
package execute_unit_pkg;

    // ALU operation select; the encoding order is part of the decode interface.
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_PASS_A,
        ALU_PASS_B,
        ALU_B4,
        ALU_IDLE,
        ALU_CSR,
        ALU_MSTD
    } alu_op_e;

    // Branch condition codes carried on FUN3.
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Ready cycles after reset before sequential-successor checking is trusted.
    localparam int unsigned WARMUP_DEPTH = 3;

    // Bits needed to hold a count from 0 up to max_val.
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/execute_unit_flush_hold_timer.sv
// Load / count-down timer; active while the remaining count is non-zero.
module flush_hold_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         active_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: reload on request, otherwise decay towards zero; frozen when disabled.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (load_i) begin
                count_d = load_val_i;
            end else if (count_q != '0) begin
                count_d = count_q - W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active_o = (count_q != '0);

endmodule

// File: rtl/execute_unit.sv
// Execute stage: ALU, branch/jump resolution, redirect flush generation,
// M-unit handshake and branch/mispredict performance counters.
module execute_unit
    import execute_unit_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_HOLD   = 4,
    parameter int unsigned FLUSH_I_HOLD = 6,
    parameter int unsigned CNT_W        = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cache_ready_i,
    input  logic            in_valid_i,
    input  alu_op_e         alu_cnt_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] comp1_i,
    input  logic [XLEN-1:0] comp2_i,
    input  logic [2:0]      fun3_i,
    input  logic            cbranch_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_base_i,
    input  logic [XLEN-1:0] jump_off_i,
    input  logic [XLEN-1:0] pc_ex_i,
    input  logic [XLEN-1:0] pc_next_i,
    input  logic            priv_jump_i,
    input  logic [XLEN-1:0] priv_addr_i,
    input  logic [XLEN-1:0] csr_data_i,
    output logic            m_start_o,
    input  logic            m_ready_i,
    input  logic [XLEN-1:0] m_result_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [XLEN-1:0] data_address_o,
    output logic            jump_final_o,
    output logic [XLEN-1:0] redirect_addr_o,
    output logic            flush_o,
    output logic            flush_i_o,
    output logic            stall_o,
    output logic            predicted_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] miss_count_o
);

    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned FhW  = cnt_bits(FLUSH_HOLD);
    localparam int unsigned FihW = cnt_bits(FLUSH_I_HOLD);
    localparam logic [XLEN-1:0] Four = XLEN'(4);

    logic [ShW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            cond;
    logic            taken;
    logic            seq_check;
    logic            resolved;
    logic            mispredict;
    logic            m_req;

    logic [WARMUP_DEPTH-1:0] warm_q, warm_d;
    logic [CNT_W-1:0]        br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

    assign shamt = a_i[ShW-1:0];

    // ALU; operand order is reversed for SUB/SLT/shifts (B op A).
    always_comb begin
        alu_res = '0;
        unique case (alu_cnt_i)
            ALU_ADD:    alu_res = a_i + b_i;
            ALU_SUB:    alu_res = b_i - a_i;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(b_i) < $signed(a_i))};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (b_i < a_i)};
            ALU_SLL:    alu_res = b_i << shamt;
            ALU_SRL:    alu_res = b_i >> shamt;
            ALU_SRA:    alu_res = $signed(b_i) >>> shamt;
            ALU_XOR:    alu_res = a_i ^ b_i;
            ALU_OR:     alu_res = a_i | b_i;
            ALU_AND:    alu_res = a_i & b_i;
            ALU_PASS_A: alu_res = a_i;
            ALU_PASS_B: alu_res = b_i;
            ALU_B4:     alu_res = b_i + Four;
            ALU_IDLE:   alu_res = '0;
            ALU_CSR:    alu_res = csr_data_i;
            ALU_MSTD:   alu_res = m_result_i;
            default:    alu_res = '0;
        endcase
    end

    // Branch condition from the compare operands.
    always_comb begin
        cond = 1'b0;
        case (fun3_i)
            F3_BEQ:  cond = (comp1_i == comp2_i);
            F3_BNE:  cond = (comp1_i != comp2_i);
            F3_BLT:  cond = ($signed(comp1_i) < $signed(comp2_i));
            F3_BGE:  cond = ($signed(comp1_i) >= $signed(comp2_i));
            F3_BLTU: cond = (comp1_i < comp2_i);
            F3_BGEU: cond = (comp1_i >= comp2_i);
            default: cond = 1'b0;
        endcase
    end

    // Control resolution; PRIV_JUMP has priority over branch/jump.
    always_comb begin
        taken = priv_jump_i | (cbranch_i ? cond : jump_i);
        if (priv_jump_i) begin
            redirect_addr_o = priv_addr_i;
        end else if (cbranch_i ? cond : jump_i) begin
            redirect_addr_o = jump_base_i + jump_off_i;
        end else begin
            redirect_addr_o = pc_ex_i + Four;
        end
    end

    // M-unit request is qualified by reset so it drops as soon as reset asserts.
    assign m_req        = rst_ni & in_valid_i & (alu_cnt_i == ALU_MSTD) & ~flush_i_o;
    assign m_start_o    = m_req;
    assign stall_o      = m_req & ~m_ready_i;

    assign jump_final_o = taken & in_valid_i & ~flush_i_o;
    assign seq_check    = warm_q[WARMUP_DEPTH-1] & in_valid_i & ~taken & ~flush_i_o;
    // A stalled instruction has not completed yet, so it is not counted until it does.
    assign resolved     = (jump_final_o | seq_check) & ~stall_o;
    assign mispredict   = resolved & (pc_next_i != redirect_addr_o);
    assign predicted_o  = ~mispredict;

    assign wb_data_o      = flush_i_o ? '0 : alu_res;
    assign data_address_o = a_i + b_i;

    // Next state for warm-up shifter and performance counters.
    always_comb begin
        warm_d     = warm_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cache_ready_i) begin
            warm_d = {warm_q[WARMUP_DEPTH-2:0], 1'b1};
            if (resolved) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (mispredict) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    // Warm-up and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            warm_q     <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            warm_q     <= warm_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_count_o   = br_cnt_q;
    assign miss_count_o = miss_cnt_q;

    flush_hold_timer #(
        .W (FhW)
    ) u_flush_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (cache_ready_i),
        .load_i     (mispredict),
        .load_val_i (FhW'(FLUSH_HOLD)),
        .active_o   (flush_o)
    );

    flush_hold_timer #(
        .W (FihW)
    ) u_flush_i_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (cache_ready_i),
        .load_i     (mispredict),
        .load_val_i (FihW'(FLUSH_I_HOLD)),
        .active_o   (flush_i_o)
    );

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit with a cycle-level reference model.
module tb_execute_unit;
    import execute_unit_pkg::*;

    localparam int FH  = 4;
    localparam int FIH = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_ready, in_valid, cbranch, jump, priv_jump, m_ready;
    alu_op_e     alu_cnt;
    logic [31:0] a, b, comp1, comp2, jump_base, jump_off, pc_ex, pc_next;
    logic [31:0] priv_addr, csr_data, m_result;
    logic [2:0]  fun3;
    logic        m_start, jump_final, flush, flush_i, stall, predicted;
    logic [31:0] wb_data, data_address, redirect_addr, br_count, miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: remaining flush cycles, warm-up cycles seen, counters.
    int          m_fl, m_fli, m_warm;
    logic [31:0] m_br, m_miss;
    // Expected combinational outputs for the current inputs.
    logic        e_jf, e_mstart, e_stall, e_event, e_mis;
    logic [31:0] e_redir, e_wb, e_daddr;

    execute_unit u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cache_ready_i  (cache_ready),
        .in_valid_i     (in_valid),
        .alu_cnt_i      (alu_cnt),
        .a_i            (a),
        .b_i            (b),
        .comp1_i        (comp1),
        .comp2_i        (comp2),
        .fun3_i         (fun3),
        .cbranch_i      (cbranch),
        .jump_i         (jump),
        .jump_base_i    (jump_base),
        .jump_off_i     (jump_off),
        .pc_ex_i        (pc_ex),
        .pc_next_i      (pc_next),
        .priv_jump_i    (priv_jump),
        .priv_addr_i    (priv_addr),
        .csr_data_i     (csr_data),
        .m_start_o      (m_start),
        .m_ready_i      (m_ready),
        .m_result_i     (m_result),
        .wb_data_o      (wb_data),
        .data_address_o (data_address),
        .jump_final_o   (jump_final),
        .redirect_addr_o(redirect_addr),
        .flush_o        (flush),
        .flush_i_o      (flush_i),
        .stall_o        (stall),
        .predicted_o    (predicted),
        .br_count_o     (br_count),
        .miss_count_o   (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] alu_ref(alu_op_e op, logic [31:0] x, logic [31:0] y,
                                            logic [31:0] csr, logic [31:0] mres);
        int unsigned sh;
        logic [31:0] ones;
        logic [31:0] r;
        sh   = x[4:0];
        ones = 32'hFFFF_FFFF;
        case (op)
            ALU_ADD:    r = x + y;
            ALU_SUB:    r = y - x;
            ALU_SLT:    r = ($signed(y) < $signed(x)) ? 32'd1 : 32'd0;
            ALU_SLTU:   r = (y < x) ? 32'd1 : 32'd0;
            ALU_SLL:    r = y << sh;
            ALU_SRL:    r = y >> sh;
            ALU_SRA:    r = (y >> sh) | (y[31] ? ~(ones >> sh) : 32'd0);
            ALU_XOR:    r = x ^ y;
            ALU_OR:     r = x | y;
            ALU_AND:    r = x & y;
            ALU_PASS_A: r = x;
            ALU_PASS_B: r = y;
            ALU_B4:     r = y + 32'd4;
            ALU_CSR:    r = csr;
            ALU_MSTD:   r = mres;
            default:    r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_eval();
        int  c1, c2;
        logic cnd, tk, sq;
        c1 = comp1;
        c2 = comp2;
        case (fun3)
            3'd0: cnd = (comp1 == comp2);
            3'd1: cnd = (comp1 != comp2);
            3'd4: cnd = (c1 < c2);
            3'd5: cnd = (c1 >= c2);
            3'd6: cnd = (comp1 < comp2);
            3'd7: cnd = (comp1 >= comp2);
            default: cnd = 1'b0;
        endcase
        sq = (m_fli > 0);
        tk = cbranch ? cnd : jump;
        if (priv_jump)  e_redir = priv_addr;
        else if (tk)    e_redir = jump_base + jump_off;
        else            e_redir = pc_ex + 32'd4;
        tk       = tk | priv_jump;
        e_jf     = tk && in_valid && !sq;
        e_mstart = rst_n && in_valid && (alu_cnt == ALU_MSTD) && !sq;
        e_stall  = e_mstart && !m_ready;
        e_event  = (e_jf || (m_warm >= 3 && in_valid && !tk && !sq)) && !e_stall;
        e_mis    = e_event && (pc_next != e_redir);
        e_wb     = sq ? 32'd0 : alu_ref(alu_cnt, a, b, csr_data, m_result);
        e_daddr  = a + b;
    endtask

    // Advance one clock and the model with it; ends 1 time unit after the edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (cache_ready && rst_n) begin
            if (m_warm < 3) m_warm++;
            if (e_event) m_br++;
            if (e_mis) begin
                m_miss++;
                m_fl  = FH;
                m_fli = FIH;
            end else begin
                if (m_fl > 0)  m_fl--;
                if (m_fli > 0) m_fli--;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        cache_ready = 1'b1; in_valid = 1'b0; alu_cnt = ALU_IDLE;
        a = '0; b = '0; comp1 = '0; comp2 = '0; fun3 = 3'd2;
        cbranch = 1'b0; jump = 1'b0; jump_base = '0; jump_off = '0;
        pc_ex = '0; pc_next = 32'd4; priv_jump = 1'b0; priv_addr = '0;
        csr_data = '0; m_ready = 1'b0; m_result = '0;
    endtask

    task automatic model_clear();
        m_fl = 0; m_fli = 0; m_warm = 0; m_br = '0; m_miss = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (10) tick();
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (flush !== 1'b0 || flush_i !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush: got %b/%b want 0/0", flush, flush_i);
        end
        n_tests++;
        if (br_count !== 32'd0 || miss_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", br_count, miss_count);
        end
        n_tests++;
        if (predicted !== 1'b1 || m_start !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: pred=%b mstart=%b stall=%b want 1/0/0",
                     predicted, m_start, stall);
        end
    endtask

    task automatic test_seq_warmup();
        in_valid = 1'b1; alu_cnt = ALU_ADD; pc_ex = 32'h200; pc_next = 32'h204;
        #2;
        n_tests++;
        if (predicted !== 1'b1 || jump_final !== 1'b0) begin
            n_fail++; $display("FAIL seq_early: pred=%b jf=%b want 1/0", predicted, jump_final);
        end
        tick();
        n_tests++;
        if (br_count !== 32'd0) begin
            n_fail++; $display("FAIL seq_early_br: got %0d want 0", br_count);
        end
        idle_inputs();
        repeat (3) tick();
        in_valid = 1'b1; alu_cnt = ALU_ADD; pc_ex = 32'h200; pc_next = 32'h300;
        #2;
        n_tests++;
        if (redirect_addr !== 32'h204 || predicted !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_miss: redir=%h pred=%b want 00000204/0", redirect_addr, predicted);
        end
        tick();
        n_tests++;
        if (flush !== 1'b1 || flush_i !== 1'b1 || br_count !== 32'd1 || miss_count !== 32'd1) begin
            n_fail++;
            $display("FAIL seq_flush: fl=%b fli=%b br=%0d miss=%0d want 1/1/1/1",
                     flush, flush_i, br_count, miss_count);
        end
        drain();
    endtask

    task automatic test_alu();
        idle_inputs();
        alu_cnt = ALU_SUB; a = 32'd3; b = 32'd10;
        #2;
        n_tests++;
        if (wb_data !== 32'd7) begin
            n_fail++; $display("FAIL alu_sub: got %h want 00000007", wb_data);
        end
        alu_cnt = ALU_SRA; a = 32'd4; b = 32'h8000_0000;
        #2;
        n_tests++;
        if (wb_data !== 32'hF800_0000) begin
            n_fail++; $display("FAIL alu_sra: got %h want f8000000", wb_data);
        end
        for (int i = 0; i < 48; i++) begin
            alu_cnt  = alu_op_e'($urandom_range(0, 15));
            a        = $urandom; b = $urandom; csr_data = $urandom; m_result = $urandom;
            if (i % 3 == 0) a = $urandom_range(0, 40);
            #2;
            model_eval();
            n_tests++;
            if (wb_data !== e_wb || data_address !== e_daddr) begin
                n_fail++;
                $display("FAIL alu_rand op=%0d: wb=%h addr=%h want %h %h",
                         alu_cnt, wb_data, data_address, e_wb, e_daddr);
            end
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_branch_mispredict();
        int fc, fic;
        do_reset();
        in_valid = 1'b1; cbranch = 1'b1; fun3 = 3'd0; comp1 = 32'd5; comp2 = 32'd5;
        jump_base = 32'hF0; jump_off = 32'h10; pc_ex = 32'h80; pc_next = 32'h104;
        #2;
        n_tests++;
        if (jump_final !== 1'b1 || predicted !== 1'b0 || redirect_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL beq_taken: jf=%b pred=%b redir=%h want 1/0/00000100",
                     jump_final, predicted, redirect_addr);
        end
        tick();
        n_tests++;
        if (miss_count !== 32'd1 || br_count !== 32'd1) begin
            n_fail++; $display("FAIL beq_cnt: miss=%0d br=%0d want 1/1", miss_count, br_count);
        end
        idle_inputs();
        fc = 0; fic = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (flush === 1'b1)   fc++;
            if (flush_i === 1'b1) fic++;
            tick();
        end
        n_tests++;
        if (fc != FH || fic != FIH) begin
            n_fail++; $display("FAIL beq_hold: flush=%0d flush_i=%0d want %0d/%0d", fc, fic, FH, FIH);
        end
    endtask

    task automatic test_flush_overlap();
        int fc;
        logic [31:0] br0, miss0;
        in_valid = 1'b1; jump = 1'b1; jump_base = 32'h1000; jump_off = 32'h20;
        pc_ex = 32'h40; pc_next = 32'h44;
        tick();
        br0 = br_count; miss0 = miss_count;
        jump_base = 32'h500; pc_next = 32'h9990;
        #2;
        n_tests++;
        if (jump_final !== 1'b0 || predicted !== 1'b1 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL overlap_comb: jf=%b pred=%b wb=%h want 0/1/0", jump_final, predicted, wb_data);
        end
        fc = (flush === 1'b1) ? 1 : 0;
        tick();
        n_tests++;
        if (br_count !== br0 || miss_count !== miss0) begin
            n_fail++;
            $display("FAIL overlap_cnt: br=%0d miss=%0d want %0d/%0d", br_count, miss_count, br0, miss0);
        end
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            #2;
            if (flush === 1'b1) fc++;
            tick();
        end
        n_tests++;
        if (fc != FH) begin
            n_fail++; $display("FAIL overlap_hold: flush=%0d want %0d", fc, FH);
        end
    endtask

    task automatic test_priv();
        logic [31:0] br0, miss0;
        br0 = br_count; miss0 = miss_count;
        in_valid = 1'b1; priv_jump = 1'b1; jump = 1'b1; priv_addr = 32'h8000_0000;
        jump_base = 32'h100; pc_ex = 32'h300; pc_next = 32'h8000_0000;
        #2;
        n_tests++;
        if (redirect_addr !== 32'h8000_0000 || jump_final !== 1'b1 || predicted !== 1'b1) begin
            n_fail++;
            $display("FAIL priv: redir=%h jf=%b pred=%b want 80000000/1/1",
                     redirect_addr, jump_final, predicted);
        end
        tick();
        n_tests++;
        if (br_count !== br0 + 32'd1 || miss_count !== miss0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL priv_cnt: br=%0d miss=%0d fl=%b want %0d/%0d/0",
                     br_count, miss_count, flush, br0 + 32'd1, miss0);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mstd();
        int sc, ms;
        logic [31:0] br0;
        br0 = br_count;
        in_valid = 1'b1; alu_cnt = ALU_MSTD; pc_ex = 32'h400; pc_next = 32'h404;
        m_result = 32'hDEAD_BEEF; m_ready = 1'b0;
        sc = 0; ms = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (stall === 1'b1)   sc++;
            if (m_start === 1'b1) ms++;
            tick();
        end
        n_tests++;
        if (sc != 5 || ms != 5 || br_count !== br0) begin
            n_fail++;
            $display("FAIL mstd_wait: stall=%0d mstart=%0d br=%0d want 5/5/%0d", sc, ms, br_count, br0);
        end
        m_ready = 1'b1;
        #2;
        n_tests++;
        if (stall !== 1'b0 || m_start !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mstd_done: stall=%b mstart=%b wb=%h want 0/1/deadbeef",
                     stall, m_start, wb_data);
        end
        tick();
        n_tests++;
        if (br_count !== br0 + 32'd1) begin
            n_fail++; $display("FAIL mstd_cnt: br=%0d want %0d", br_count, br0 + 32'd1);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_cache_freeze();
        int fc, fic;
        in_valid = 1'b1; jump = 1'b1; jump_base = 32'h700; pc_ex = 32'h10; pc_next = 32'h14;
        tick();
        idle_inputs();
        fc = 0; fic = 0;
        for (int i = 0; i < 20; i++) begin
            cache_ready = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            #2;
            if (flush === 1'b1)   fc++;
            if (flush_i === 1'b1) fic++;
            tick();
        end
        n_tests++;
        if (fc != FH + 3 || fic != FIH + 3) begin
            n_fail++;
            $display("FAIL freeze_hold: flush=%0d flush_i=%0d want %0d/%0d", fc, fic, FH + 3, FIH + 3);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midflush();
        in_valid = 1'b1; jump = 1'b1; jump_base = 32'h700; pc_ex = 32'h10; pc_next = 32'h14;
        tick();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (flush !== 1'b0 || flush_i !== 1'b0 || miss_count !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_flush: fl=%b fli=%b miss=%0d want 0/0/0", flush, flush_i, miss_count);
        end
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1; alu_cnt = ALU_MSTD; pc_ex = 32'h20; pc_next = 32'h24; m_ready = 1'b0;
        #2;
        n_tests++;
        if (m_start !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL rst_mop_pre: mstart=%b stall=%b want 1/1", m_start, stall);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (m_start !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_mop: mstart=%b stall=%b want 0/0", m_start, stall);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_inputs();
        model_clear();
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        int sel;
        for (int i = 0; i < 400; i++) begin
            cache_ready = ($urandom_range(0, 7) != 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            alu_cnt     = alu_op_e'($urandom_range(0, 15));
            a = $urandom; b = $urandom; csr_data = $urandom; m_result = $urandom;
            comp1 = $urandom_range(0, 7) - 3;
            comp2 = ($urandom_range(0, 2) == 0) ? comp1 : 32'($urandom_range(0, 7) - 3);
            fun3      = 3'($urandom_range(0, 7));
            cbranch   = ($urandom_range(0, 2) == 0);
            jump      = ($urandom_range(0, 4) == 0);
            priv_jump = ($urandom_range(0, 15) == 0);
            priv_addr = $urandom & 32'hFFFF_FFFC;
            jump_base = $urandom; jump_off = $urandom_range(0, 255);
            pc_ex     = $urandom & 32'hFFFF_FFFC;
            m_ready   = ($urandom_range(0, 2) != 0);
            tgt = jump_base + jump_off;
            sel = $urandom_range(0, 3);
            pc_next = (sel == 0) ? pc_ex + 32'd4 : (sel == 1) ? tgt :
                      (sel == 2) ? priv_addr : 32'($urandom);
            #2;
            model_eval();
            n_tests++;
            if (jump_final !== e_jf || redirect_addr !== e_redir || predicted !== !e_mis ||
                wb_data !== e_wb || data_address !== e_daddr || m_start !== e_mstart ||
                stall !== e_stall) begin
                n_fail++;
                $display("FAIL rand_comb %0d: jf=%b/%b redir=%h/%h pred=%b/%b wb=%h/%h ms=%b/%b st=%b/%b",
                         i, jump_final, e_jf, redirect_addr, e_redir, predicted, !e_mis,
                         wb_data, e_wb, m_start, e_mstart, stall, e_stall);
            end
            n_tests++;
            if (flush !== (m_fl > 0) || flush_i !== (m_fli > 0) ||
                br_count !== m_br || miss_count !== m_miss) begin
                n_fail++;
                $display("FAIL rand_state %0d: fl=%b fli=%b br=%0d miss=%0d want %b/%b/%0d/%0d",
                         i, flush, flush_i, br_count, miss_count, m_fl > 0, m_fli > 0, m_br, m_miss);
            end
            tick();
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_seq_warmup();
        test_alu();
        test_branch_mispredict();
        test_flush_overlap();
        test_priv();
        test_mstd();
        test_cache_freeze();
        test_reset_midflush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
